// File: rtl/slow_edge_logger_pkg.sv
// Shared types for the slow-counter event logger: event kinds, entry layout, saturating add.
package slow_edge_logger_pkg;

  localparam int TS_W_DEF  = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    EV_NONE = 2'd0,
    EV_RISE = 2'd1,
    EV_FALL = 2'd2,
    EV_SEC  = 2'd3
  } event_kind_e;

  typedef struct packed {
    event_kind_e            kind;
    logic [TS_W_DEF-1:0]    ts;
    logic [CNT_W_DEF-1:0]   count;
  } log_entry_t;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

endpackage

// File: rtl/logger_fifo.sv
// Synchronous show-ahead FIFO; head data is 0 while empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module logger_fifo
  import slow_edge_logger_pkg::*;
#(
  parameter  int W     = 22,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wr_dat,
  output logic [W-1:0]  rd_dat,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == '0);
  assign level     = r_level;
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign rd_dat    = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level <= r_level + LW'(w_do_push) - LW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[r_wr_ptr] <= wr_dat;
  end

endmodule

// File: rtl/slow_edge_logger.sv
// Timestamps slow_in edges and sec_in rises into a show-ahead FIFO drained by valid/ready.
// Optional DROP_COUNT_EN adds a saturating lost-event counter alongside the sticky overflow.
module slow_edge_logger
  import slow_edge_logger_pkg::*;
#(
  parameter  int SLOW_DEPTH = CNT_W_DEF,
  parameter  int TS_WIDTH   = TS_W_DEF,
  parameter  int FIFO_DEPTH = 8,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1,
  localparam int EW         = 2 + TS_WIDTH + SLOW_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slow_in,
  input  logic [SLOW_DEPTH-1:0] count_in,
  input  logic                  sec_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            out_kind,
  output logic [TS_WIDTH-1:0]   out_ts,
  output logic [SLOW_DEPTH-1:0] out_count,
  output logic [LW-1:0]         fifo_level,
  output logic                  overflow
`ifdef DROP_COUNT_EN
  ,
  output logic [7:0]            drop_count
`endif
);

  logic [TS_WIDTH-1:0] r_ts;
  logic                r_primed;
  logic                r_slow_prev;
  logic                r_sec_prev;
  logic                r_overflow;
  event_kind_e         w_kind;
  logic                w_slow_edge;
  logic                w_sec_edge;
  logic                w_collision;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_drop;
  logic [EW-1:0]       w_wr_dat;
  logic [EW-1:0]       w_rd_dat;

  assign w_slow_edge = r_primed & (slow_in ^ r_slow_prev);
  assign w_sec_edge  = r_primed & sec_in & ~r_sec_prev;
  assign w_collision = w_slow_edge & w_sec_edge;

  always_comb begin
    w_kind = EV_NONE;
    if (w_slow_edge)     w_kind = slow_in ? EV_RISE : EV_FALL;
    else if (w_sec_edge) w_kind = EV_SEC;
  end

  assign w_push   = (w_kind != EV_NONE);
  assign w_pop    = out_valid & out_ready;
  assign w_drop   = w_push & w_full & ~w_pop;
  assign w_wr_dat = {w_kind, r_ts, count_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ts        <= '0;
      r_primed    <= 1'b0;
      r_slow_prev <= 1'b0;
      r_sec_prev  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_ts        <= r_ts + TS_WIDTH'(1);
      r_primed    <= 1'b1;
      r_slow_prev <= slow_in;
      r_sec_prev  <= sec_in;
      r_overflow  <= r_overflow | w_collision | w_drop;
    end
  end

`ifdef DROP_COUNT_EN
  logic [7:0] r_drop_count;

  // A single cycle can lose two events: the colliding SEC and a dropped edge.
  always_ff @(posedge clk) begin
    if (rst) r_drop_count <= '0;
    else     r_drop_count <= sat_add8(r_drop_count, {1'b0, w_collision} + {1'b0, w_drop});
  end

  assign drop_count = r_drop_count;
`endif

  logger_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (w_push),
    .pop    (w_pop),
    .wr_dat (w_wr_dat),
    .rd_dat (w_rd_dat),
    .full   (w_full),
    .empty  (w_empty),
    .level  (fifo_level)
  );

  assign out_valid = ~w_empty;
  assign out_kind  = w_rd_dat[EW-1 -: 2];
  assign out_ts    = w_rd_dat[SLOW_DEPTH +: TS_WIDTH];
  assign out_count = w_rd_dat[SLOW_DEPTH-1:0];
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_slow_edge_logger.sv
// Directed bench for slow_edge_logger; drop_count checks compile in with DROP_COUNT_EN.
module tb_slow_edge_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        slow_in;
  logic [3:0]  count_in;
  logic        sec_in;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_kind;
  logic [15:0] out_ts;
  logic [3:0]  out_count;
  logic [3:0]  fifo_level;
  logic        overflow;
`ifdef DROP_COUNT_EN
  logic [7:0]  drop_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  slow_edge_logger dut (
    .clk        (clk),
    .rst        (rst),
    .slow_in    (slow_in),
    .count_in   (count_in),
    .sec_in     (sec_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_kind   (out_kind),
    .out_ts     (out_ts),
    .out_count  (out_count),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [1:0] k, input logic [15:0] ts,
                          input logic [3:0] c);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_kind"},  32'(out_kind),  32'(k));
    chk({tag, "_ts"},    32'(out_ts),    32'(ts));
    chk({tag, "_count"}, 32'(out_count), 32'(c));
  endtask

  initial begin
    logic [4:0] v;
    rst = 1'b1; slow_in = 1'b0; count_in = '0; sec_in = 1'b0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf",   32'(overflow), 32'd0);
    chk("rst_kind",  32'(out_kind), 32'd0);
    chk("rst_ts",    32'(out_ts), 32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
`ifdef DROP_COUNT_EN
    chk("rst_drop",  32'(drop_count), 32'd0);
`endif

    // Test 1: counter sweep, RISE at ts 8 (count 8), FALL at ts 16 (count 0)
    rst = 1'b0;
    tick();
    for (int i = 1; i <= 16; i++) begin
      v = 5'(i);
      count_in = v[3:0];
      slow_in  = v[3];
      tick();
    end
    chk("t1_level", 32'(fifo_level), 32'd2);
    chk_head("t1_rise", 2'd1, 16'd8, 4'd8);
    out_ready = 1'b1;
    tick();
    chk_head("t1_fall", 2'd2, 16'd16, 4'd0);
    chk("t1_level1", 32'(fifo_level), 32'd1);
    tick();
    chk("t1_empty_valid", 32'(out_valid), 32'd0);
    chk("t1_empty_kind",  32'(out_kind), 32'd0);
    out_ready = 1'b0;

    // Test 2: slow_in high at reset release is not a RISE
    rst = 1'b1; slow_in = 1'b1;
    tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t2_no_rise", 32'(fifo_level), 32'd0);
    slow_in = 1'b0;
    tick();
    chk_head("t2_fall", 2'd2, 16'd4, 4'd0);
    slow_in = 1'b1;
    tick();
    out_ready = 1'b1;
    tick();
    chk_head("t2_rise", 2'd1, 16'd5, 4'd0);
    tick();
    chk("t2_drained", 32'(fifo_level), 32'd0);
    out_ready = 1'b0;

    // Test 3: 9 SEC pulses into an 8-deep FIFO with no consumer
    rst = 1'b1; slow_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 0; k < 9; k++) begin
      count_in = 4'(k);
      sec_in = 1'b1;
      tick();
      sec_in = 1'b0;
      tick();
    end
    chk("t3_level", 32'(fifo_level), 32'd8);
    chk("t3_ovf",   32'(overflow), 32'd1);
`ifdef DROP_COUNT_EN
    chk("t3_drop",  32'(drop_count), 32'd1);
`endif
    chk_head("t3_head", 2'd3, 16'd1, 4'd0);

    // Test 4: full FIFO, pop and RISE in the same cycle (ts 19)
    out_ready = 1'b1; slow_in = 1'b1; count_in = 4'hA;
    tick();
    chk("t4_level", 32'(fifo_level), 32'd8);
    chk("t4_ovf",   32'(overflow), 32'd1);
`ifdef DROP_COUNT_EN
    chk("t4_drop",  32'(drop_count), 32'd1);
`endif
    for (int k = 1; k < 8; k++) begin
      chk_head($sformatf("t3_sec%0d", k), 2'd3, 16'(1 + 2 * k), 4'(k));
      tick();
    end
    chk_head("t4_rise", 2'd1, 16'd19, 4'hA);
    tick();
    chk("t4_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Test 5: SEC and RISE together -> one RISE, overflow set
    rst = 1'b1; slow_in = 1'b0; sec_in = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("t5_ovf0", 32'(overflow), 32'd0);
    slow_in = 1'b1; sec_in = 1'b1; count_in = 4'd5;
    tick();
    chk("t5_level", 32'(fifo_level), 32'd1);
    chk_head("t5_rise", 2'd1, 16'd1, 4'd5);
    chk("t5_ovf", 32'(overflow), 32'd1);
`ifdef DROP_COUNT_EN
    chk("t5_drop", 32'(drop_count), 32'd1);
`endif

    // Test 6: reset with 3 entries queued flushes everything, ts restarts
    slow_in = 1'b0; sec_in = 1'b0;
    tick();
    slow_in = 1'b1;
    tick();
    chk("t6_level3", 32'(fifo_level), 32'd3);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    chk("t6_ovf",   32'(overflow), 32'd0);
`ifdef DROP_COUNT_EN
    chk("t6_drop",  32'(drop_count), 32'd0);
`endif
    rst = 1'b0; slow_in = 1'b0; out_ready = 1'b0;
    tick(); tick();
    slow_in = 1'b1; count_in = 4'd3;
    tick();
    chk_head("t6_ts_restart", 2'd1, 16'd2, 4'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
